fifo_packet_vc: RTL and testbench

- Parametrised successor of the single-queue packet input buffer.
- Holds NUM_VC independent packet_t queues (virtual channels) behind one router input port.
- Each queue has its own first-word-fall-through head output, valid, enable/credit, almost-full flag and occupancy count.
- Sits between the upstream link and the router's VC allocator/switch; each VC's backpressure is independent, so a blocked VC does not stall the others.

---
 rtl/fifo_packet_vc.sv | 112 +++++++++++
 tb/tb_fifo_packet_vc.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fifo_packet_vc.sv
// Multi-VC packet input buffer: NUM_VC independent first-word-fall-through queues
// sharing one write port, with per-VC pop, credit, almost-full, count and sticky error.
`ifndef INPUT_QUEUE_DEPTH
`define INPUT_QUEUE_DEPTH 4
`endif

package fifo_packet_vc_pkg;
  localparam int PKT_W = 32;
  typedef logic [PKT_W-1:0] packet_t;
endpackage

module fifo_packet_vc
  import fifo_packet_vc_pkg::*;
#(
  parameter int DEPTH    = `INPUT_QUEUE_DEPTH,
  parameter int NUM_VC   = 2,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  packet_t           i_data,
  input  logic              i_data_val,
  input  logic [VC_W-1:0]   i_vc,
  input  logic [NUM_VC-1:0] i_en,
  output packet_t           o_data        [NUM_VC],
  output logic [NUM_VC-1:0] o_data_val,
  output logic [NUM_VC-1:0] o_en,
  output logic [NUM_VC-1:0] o_almost_full,
  output logic [CNT_W-1:0]  o_count       [NUM_VC],
  output logic [NUM_VC-1:0] o_err
);

  localparam int PTR_W = $clog2(DEPTH);

  packet_t           mem      [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr   [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr   [NUM_VC];
  logic [PTR_W-1:0]  wr_ptr_n [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_n [NUM_VC];
  logic [CNT_W-1:0]  count_n  [NUM_VC];
  packet_t           head_n   [NUM_VC];
  logic [NUM_VC-1:0] wr_fire;
  logic [NUM_VC-1:0] pop;
  logic [NUM_VC-1:0] err_n;
  logic              vc_ok;
  logic              wr_req;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every variable driven here gets a default before any condition, so no latches.
  always_comb begin
    // One extra bit keeps the range check meaningful when NUM_VC is a power of two.
    vc_ok  = ({1'b0, i_vc} < (VC_W + 1)'(NUM_VC));
    wr_req = ce && i_data_val && vc_ok;
    err_n  = o_err;
    for (int v = 0; v < NUM_VC; v++) begin
      pop[v]     = ce && i_en[v] && (o_count[v] != '0);
      // A pop in the same edge frees the slot, so a full VC can still take the write.
      wr_fire[v] = wr_req && (i_vc == VC_W'(v)) &&
                   ((o_count[v] != CNT_W'(DEPTH)) || pop[v]);
      wr_ptr_n[v] = wr_fire[v] ? ptr_inc(wr_ptr[v]) : wr_ptr[v];
      rd_ptr_n[v] = pop[v]     ? ptr_inc(rd_ptr[v]) : rd_ptr[v];
      count_n[v]  = o_count[v] + CNT_W'(wr_fire[v]) - CNT_W'(pop[v]);

      // A lone entry that arrives this edge is not in mem yet, so bypass it to the head.
      head_n[v] = o_data[v];
      if (wr_fire[v] && (count_n[v] == CNT_W'(1)))
        head_n[v] = i_data;
      else if (count_n[v] != '0)
        head_n[v] = mem[v][rd_ptr_n[v]];

      if (wr_req && (i_vc == VC_W'(v)) && !wr_fire[v]) err_n[v] = 1'b1;
      if (ce && i_en[v] && (o_count[v] == '0))          err_n[v] = 1'b1;
    end
    if (ce && i_data_val && !vc_ok) err_n[0] = 1'b1;
  end

  // NOTE: storage is cleared on reset because queued packets must not survive it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_data_val    <= '0;
      o_en          <= '1;
      o_almost_full <= '0;
      o_err         <= '0;
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr[v]  <= '0;
        rd_ptr[v]  <= '0;
        o_count[v] <= '0;
        o_data[v]  <= '0;
        for (int d = 0; d < DEPTH; d++) mem[v][d] <= '0;
      end
    end else if (ce) begin
      o_err <= err_n;
      for (int v = 0; v < NUM_VC; v++) begin
        if (wr_fire[v]) mem[v][wr_ptr[v]] <= i_data;
        wr_ptr[v]        <= wr_ptr_n[v];
        rd_ptr[v]        <= rd_ptr_n[v];
        o_count[v]       <= count_n[v];
        o_data[v]        <= head_n[v];
        o_data_val[v]    <= (count_n[v] != '0);
        o_en[v]          <= (count_n[v] != CNT_W'(DEPTH));
        o_almost_full[v] <= (count_n[v] >= CNT_W'(AF_LEVEL));
      end
    end
  end

endmodule

// File: tb/tb_fifo_packet_vc.sv
// Directed plus randomized bench for fifo_packet_vc, checked against queue-based
// reference behaviour of independent per-VC FIFOs.
module tb_fifo_packet_vc;
  import fifo_packet_vc_pkg::*;

  localparam int DEPTH    = 4;
  localparam int NUM_VC   = 2;
  localparam int AF_LEVEL = 3;
  localparam int VC_W     = 1;
  localparam int CNT_W    = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ce;
  packet_t           i_data;
  logic              i_data_val;
  logic [VC_W-1:0]   i_vc;
  logic [NUM_VC-1:0] i_en;
  packet_t           o_data [NUM_VC];
  logic [NUM_VC-1:0] o_data_val;
  logic [NUM_VC-1:0] o_en;
  logic [NUM_VC-1:0] o_almost_full;
  logic [CNT_W-1:0]  o_count [NUM_VC];
  logic [NUM_VC-1:0] o_err;

  always #5 clk = ~clk;

  fifo_packet_vc #(.DEPTH(DEPTH), .NUM_VC(NUM_VC), .AF_LEVEL(AF_LEVEL)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ce            (ce),
    .i_data        (i_data),
    .i_data_val    (i_data_val),
    .i_vc          (i_vc),
    .i_en          (i_en),
    .o_data        (o_data),
    .o_data_val    (o_data_val),
    .o_en          (o_en),
    .o_almost_full (o_almost_full),
    .o_count       (o_count),
    .o_err         (o_err)
  );

  // Reference: each VC is a plain queue; the head output keeps its last value when empty.
  packet_t           q [NUM_VC][$];
  packet_t           exp_head [NUM_VC];
  logic [NUM_VC-1:0] exp_err;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all(input string phase);
    for (int v = 0; v < NUM_VC; v++) begin
      check($sformatf("%s_data%0d", phase, v),  32'(o_data[v]), 32'(exp_head[v]));
      check($sformatf("%s_val%0d", phase, v),   32'(o_data_val[v]), 32'(q[v].size() != 0));
      check($sformatf("%s_en%0d", phase, v),    32'(o_en[v]), 32'(q[v].size() != DEPTH));
      check($sformatf("%s_af%0d", phase, v),    32'(o_almost_full[v]), 32'(q[v].size() >= AF_LEVEL));
      check($sformatf("%s_count%0d", phase, v), 32'(o_count[v]), 32'(q[v].size()));
      check($sformatf("%s_err%0d", phase, v),   32'(o_err[v]), 32'(exp_err[v]));
    end
  endtask

  task automatic step(input string phase, input logic rst, input logic c, input logic dv,
                      input logic [VC_W-1:0] vc, input logic [NUM_VC-1:0] en, input packet_t d);
    reset_n    = ~rst;
    ce         = c;
    i_data_val = dv;
    i_vc       = vc;
    i_en       = en;
    i_data     = d;
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        q[v].delete();
        exp_head[v] = '0;
      end
      exp_err = '0;
    end else if (c) begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (en[v]) begin
          if (q[v].size() > 0) void'(q[v].pop_front());
          else exp_err[v] = 1'b1;
        end
      end
      if (dv) begin
        if (int'(vc) >= NUM_VC)      exp_err[0] = 1'b1;
        else if (q[vc].size() < DEPTH) q[vc].push_back(d);
        else                           exp_err[vc] = 1'b1;
      end
      for (int v = 0; v < NUM_VC; v++)
        if (q[v].size() > 0) exp_head[v] = q[v][0];
    end
    @(posedge clk);
    #1;
    compare_all(phase);
  endtask

  initial begin
    packet_t a;
    reset_n = 1'b0; ce = 1'b1; i_data_val = 1'b0; i_vc = '0; i_en = '0; i_data = '0;
    for (int v = 0; v < NUM_VC; v++) exp_head[v] = '0;
    exp_err = '0;

    step("reset", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, '0);
    step("reset", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, '0);

    a = $urandom;
    step("wr_a", 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, a);
    check("wr_a_val_vec", 32'(o_data_val), 32'h1);
    check("wr_a_head", 32'(o_data[0]), 32'(a));

    for (int i = 0; i < 4; i++) step("fill1", 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, $urandom);
    step("overflow1", 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, $urandom);

    for (int i = 0; i < 8; i++) step("full_pw1", 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, $urandom);

    step("pw0", 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, $urandom);
    step("pop0", 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, '0);

    for (int i = 0; i < 4; i++) step("fill0", 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, $urandom);
    for (int i = 0; i < 10; i++) step("stream1", 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, $urandom);
    for (int i = 0; i < 4; i++) step("drain1", 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, '0);

    for (int i = 0; i < 80; i++)
      step("rand", 1'b0, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);

    step("reset2", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, '0);
    step("part", 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, $urandom);
    step("part", 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, $urandom);
    step("part", 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, $urandom);
    for (int i = 0; i < 3; i++)
      step("ce_off", 1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 2'b11, $urandom);
    step("reset3", 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, $urandom);
    check("reset3_en_vec", 32'(o_en), 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
